// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and enums used by the encoder and decoder.
// Holds opcode/funct values, the op_sel enumeration and encoder FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  typedef enum logic [3:0] {
    SEL_ADD  = 4'd0,
    SEL_SUB  = 4'd1,
    SEL_SLT  = 4'd2,
    SEL_MUL  = 4'd3,
    SEL_ADDI = 4'd4,
    SEL_LW   = 4'd5,
    SEL_SW   = 4'd6,
    SEL_BEQ  = 4'd7,
    SEL_J    = 4'd8
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: symbolic fields -> 32-bit MIPS word plus legal flag.
// Ports: op_sel/rs/rt/rd/imm/target in; word, legal out. Unused fields are 0.
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (1'b1)
      (op_sel == SEL_ADD):
        word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      (op_sel == SEL_SUB):
        word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      (op_sel == SEL_SLT):
        word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      (op_sel == SEL_MUL):
        word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_MUL};
      (op_sel == SEL_ADDI):
        word = {OP_ADDI, rs, rt, imm};
      (op_sel == SEL_LW):
        word = {OP_LW, rs, rt, imm};
      (op_sel == SEL_SW):
        word = {OP_SW, rs, rt, imm};
      (op_sel == SEL_BEQ):
        word = {OP_BEQ, rs, rt, imm};
      (op_sel == SEL_J):
        word = {OP_J, target};
      default:
        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes streamed instructions and writes them to imem.
// Ports: start/base_addr arm, valid/ready fields in, imem write, status out.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count,
  output logic          err_illegal
);

  localparam logic [AW-1:0] MAX_ADDR = '1;

  enc_state_e    state;
  enc_state_e    nxt;
  logic [AW-1:0] ptr;
  logic [AW:0]   cnt;
  logic          err;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          loading;
  logic          accept;
  logic          wr;
  logic          at_max;

  mips_instr_pack u_pack (
    .op_sel (op_sel),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm),
    .target (target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign loading = (state == ST_LOAD);
  assign accept  = in_valid & loading;
  assign wr      = accept & enc_legal;
  assign at_max  = (ptr == MAX_ADDR);

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE:
        if (start) nxt = ST_LOAD;
      ST_LOAD:
        // Last slot of memory ends the program; pointer must not wrap.
        if (accept && (in_last || (enc_legal && at_max)))
          nxt = ST_DONE;
      default:
        nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= nxt;
      we_q  <= wr;
      if (start && !loading) begin
        ptr <= base_addr;
        cnt <= '0;
        err <= 1'b0;
      end
      if (wr) begin
        addr_q  <= ptr;
        wdata_q <= enc_word;
        cnt     <= cnt + (AW+1)'(1);
        if (!at_max) ptr <= ptr + AW'(1);
      end
      if (accept && !enc_legal) err <= 1'b1;
    end
  end

  assign in_ready    = loading;
  assign busy        = loading;
  assign done        = (state == ST_DONE);
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign word_count  = cnt;
  assign err_illegal = err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed + randomized programs.
// Expected words come from a table-driven arithmetic encoding model.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_sel = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [8:0]  word_count;
  logic        err_illegal;

  int tests = 0;
  int fails = 0;

  longint unsigned opc_tab [9] = '{0, 0, 0, 0, 8, 35, 43, 4, 2};
  longint unsigned fn_tab  [4] = '{32, 34, 42, 28};

  mips_instr_encoder #(.AW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_sel      (op_sel),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .target      (target),
    .in_last     (in_last),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .word_count  (word_count),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  // {legal, word} from the instruction-format rules
  function automatic logic [32:0] ref_enc(
    input int op,
    input longint unsigned s, t, d, i, g
  );
    longint unsigned w;
    if (op < 0 || op > 8) return {1'b0, 32'h0};
    if (op <= 3)
      w = s * 64'd2097152 + t * 64'd65536
        + d * 64'd2048 + fn_tab[op];
    else if (op <= 7)
      w = opc_tab[op] * 64'd67108864
        + s * 64'd2097152 + t * 64'd65536 + i;
    else
      w = opc_tab[op] * 64'd67108864 + g;
    return {1'b1, w[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(
    input logic [3:0] o, input logic [4:0] s, t, d,
    input logic [15:0] i, input logic [25:0] g,
    input logic l
  );
    in_valid = 1'b1;
    op_sel = o; rs = s; rt = t; rd = d;
    imm = i; target = g; in_last = l;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if ({imem_we, busy, done, in_ready, err_illegal} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000",
        {imem_we, busy, done, in_ready, err_illegal});
    end
    tests++;
    if (word_count !== 9'd0) begin
      fails++;
      $display("FAIL reset_count got %0d want 0", word_count);
    end
    tests++;
    if (imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_bus got %h/%h want 0/0",
        imem_addr, imem_wdata);
    end
  endtask

  task automatic test_single_add();
    do_start(8'h10);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL add_busy got %b%b want 11", busy, in_ready);
    end
    beat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h10) begin
      fails++;
      $display("FAIL add_wr got we=%b a=%h want 1/10",
        imem_we, imem_addr);
    end
    tests++;
    if (imem_wdata !== 32'h00221820) begin
      fails++;
      $display("FAIL add_data got %h want 00221820", imem_wdata);
    end
    tests++;
    if (done !== 1'b1 || word_count !== 9'd1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL add_done got d=%b c=%0d r=%b want 1/1/0",
        done, word_count, in_ready);
    end
    tick();
    tests++;
    if (imem_we !== 1'b0) begin
      fails++;
      $display("FAIL add_strobe got %b want 0", imem_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h8FA80004;
    exp_d[1] = 32'h1022FFFF;
    exp_d[2] = 32'h08000010;
    do_start(8'h20);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: beat(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
        1: beat(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        default: beat(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
      endcase
      tests++;
      if (imem_we !== 1'b1 || imem_addr !== 8'(8'h20 + k)
          || imem_wdata !== exp_d[k]) begin
        fails++;
        $display("FAIL b2b_%0d got we=%b a=%h d=%h want 1/%h/%h",
          k, imem_we, imem_addr, imem_wdata, 8'(8'h20 + k), exp_d[k]);
      end
    end
    tests++;
    if (done !== 1'b1 || word_count !== 9'd3) begin
      fails++;
      $display("FAIL b2b_done got d=%b c=%0d want 1/3",
        done, word_count);
    end
  endtask

  task automatic test_field_masking();
    do_start(8'h00);
    beat(4'd4, 5'd0, 5'd1, 5'd31, 16'd5, 26'h3FFFFFF, 1'b0);
    tests++;
    if (imem_wdata !== 32'h20010005 || imem_addr !== 8'h00) begin
      fails++;
      $display("FAIL addi_mask got %h@%h want 20010005@00",
        imem_wdata, imem_addr);
    end
    beat(4'd3, 5'd2, 5'd3, 5'd4, 16'hABCD, 26'h1234567, 1'b1);
    tests++;
    if (imem_wdata !== 32'h0043201C || imem_addr !== 8'h01) begin
      fails++;
      $display("FAIL mul_mask got %h@%h want 0043201C@01",
        imem_wdata, imem_addr);
    end
  endtask

  task automatic test_illegal();
    do_start(8'h40);
    beat(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
    beat(4'd12, 5'd7, 5'd7, 5'd7, 16'h7, 26'h7, 1'b0);
    tests++;
    if (imem_we !== 1'b0 || err_illegal !== 1'b1) begin
      fails++;
      $display("FAIL ill_nowr got we=%b err=%b want 0/1",
        imem_we, err_illegal);
    end
    tests++;
    if (word_count !== 9'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ill_count got c=%0d b=%b want 1/1",
        word_count, busy);
    end
    beat(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h41
        || imem_wdata !== 32'h00853022) begin
      fails++;
      $display("FAIL ill_next got we=%b %h@%h want 1 00853022@41",
        imem_we, imem_wdata, imem_addr);
    end
    tests++;
    if (word_count !== 9'd2 || err_illegal !== 1'b1 || done !== 1'b1) begin
      fails++;
      $display("FAIL ill_end got c=%0d e=%b d=%b want 2/1/1",
        word_count, err_illegal, done);
    end
    do_start(8'h00);
    tests++;
    if (err_illegal !== 1'b0 || word_count !== 9'd0) begin
      fails++;
      $display("FAIL ill_clear got e=%b c=%0d want 0/0",
        err_illegal, word_count);
    end
    beat(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    tests++;
    if (done !== 1'b1 || err_illegal !== 1'b1 || imem_we !== 1'b0) begin
      fails++;
      $display("FAIL ill_last got d=%b e=%b we=%b want 1/1/0",
        done, err_illegal, imem_we);
    end
  endtask

  task automatic test_max_addr();
    do_start(8'hFE);
    beat(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 8'hFE || busy !== 1'b1) begin
      fails++;
      $display("FAIL max_w0 got we=%b a=%h b=%b want 1/FE/1",
        imem_we, imem_addr, busy);
    end
    beat(4'd6, 5'd3, 5'd4, 5'd0, 16'h8, 26'h0, 1'b0);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 8'hFF
        || imem_wdata !== 32'hAC640008) begin
      fails++;
      $display("FAIL max_w1 got we=%b %h@%h want 1 AC640008@FF",
        imem_we, imem_wdata, imem_addr);
    end
    tests++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL max_done got d=%b r=%b want 1/0", done, in_ready);
    end
    beat(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
    tests++;
    if (imem_we !== 1'b0 || word_count !== 9'd2) begin
      fails++;
      $display("FAIL max_third got we=%b c=%0d want 0/2",
        imem_we, word_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] e;
    do_start(8'h30);
    beat(4'd0, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0, 1'b0);
    tests++;
    if (imem_we !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre got we=%b want 1", imem_we);
    end
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tests++;
    if ({imem_we, busy, done, in_ready, err_illegal} !== 5'b0
        || word_count !== 9'd0) begin
      fails++;
      $display("FAIL rmid_flags got %b c=%0d want 00000/0",
        {imem_we, busy, done, in_ready, err_illegal}, word_count);
    end
    tests++;
    if (imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL rmid_bus got %h/%h want 0/0",
        imem_addr, imem_wdata);
    end
    do_start(8'h50);
    beat(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1);
    e = ref_enc(1, 4, 5, 6, 0, 0);
    tests++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h50
        || imem_wdata !== e[31:0] || word_count !== 9'd1) begin
      fails++;
      $display("FAIL rmid_after got we=%b %h@%h c=%0d want 1 %h@50 1",
        imem_we, imem_wdata, imem_addr, word_count, e[31:0]);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      int unsigned mptr;
      int unsigned mcnt;
      int unsigned n;
      int unsigned sent;
      int guard;
      logic mload;
      logic merr;
      mptr = (p % 3 == 0) ? $urandom_range(250, 255)
                          : $urandom_range(0, 255);
      do_start(8'(mptr));
      mcnt = 0; merr = 1'b0; mload = 1'b1;
      n = $urandom_range(1, 10);
      sent = 0; guard = 0;
      while (mload && guard < 200) begin
        logic v;
        logic [32:0] e;
        logic ewe;
        int op;
        guard++;
        v = ($urandom % 4) != 0;
        op = ($urandom % 5 == 0) ? $urandom_range(9, 15)
                                 : $urandom_range(0, 8);
        in_valid = v;
        op_sel = 4'(op);
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        imm = 16'($urandom); target = 26'($urandom);
        in_last = (sent == n - 1);
        e = ref_enc(op, rs, rt, rd, imm, target);
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL rnd_ready p%0d got %b want 1", p, in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        ewe = 1'b0;
        if (v) begin
          sent++;
          if (e[32]) begin
            ewe = 1'b1;
            mcnt++;
            tests++;
            if (imem_addr !== 8'(mptr) || imem_wdata !== e[31:0]) begin
              fails++;
              $display("FAIL rnd_wr p%0d op%0d got %h@%h want %h@%h",
                p, op, imem_wdata, imem_addr, e[31:0], 8'(mptr));
            end
            if (mptr == 255) mload = 1'b0;
            else mptr++;
          end else begin
            merr = 1'b1;
          end
          if (sent == n) mload = 1'b0;
        end
        tests++;
        if (imem_we !== ewe || word_count !== 9'(mcnt)
            || err_illegal !== merr || done !== !mload) begin
          fails++;
          $display("FAIL rnd_st p%0d got we%b c%0d e%b d%b want %b %0d %b %b",
            p, imem_we, word_count, err_illegal, done,
            ewe, mcnt, merr, !mload);
        end
      end
      if (mload) begin
        tests++;
        fails++;
        $display("FAIL rnd_timeout p%0d got busy want done", p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_field_masking();
    test_illegal();
    test_max_addr();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Sequential instruction encoder and program loader: the inverse of the control decoder.
- Accepts symbolic instructions (operation select plus register, immediate and target fields) over a valid/ready stream.
- Packs each into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses from a programmed base.
- Used by the bench and boot path to load programs the datapath then decodes; supports exactly the opcode/funct set the datapath implements.

Parameters:
- AW, 8, instruction-memory word-address width; last address MAX_ADDR = 2^AW-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; latches base_addr and arms loading (honoured in IDLE/DONE only)
- base_addr  input  AW  first word address to write
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder accepts this cycle
- op_sel  input  4  0 ADD, 1 SUB, 2 SLT, 3 MUL, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 J, 9-15 illegal
- rs, rt, rd  input  5 each  register fields
- imm  input  16  immediate / offset
- target  input  26  jump target
- in_last  input  1  marks final instruction of program
- imem_we  output  1  memory write strobe
- imem_addr  output  AW  write word address
- imem_wdata  output  32  encoded instruction
- busy  output  1  state == LOAD
- done  output  1  state == DONE
- word_count  output  AW+1  words written since start
- err_illegal  output  1  sticky; an illegal op_sel was accepted

Behaviour:
- FSM states IDLE, LOAD, DONE. Reset -> IDLE. Reset values: all outputs 0, write pointer 0.
- IDLE/DONE + start:
  - -> LOAD; pointer <= base_addr.
  - word_count and err_illegal cleared.
- LOAD:
  - in_ready = 1. Accept = in_valid & in_ready. start ignored.
  - Legal accept at cycle N: cycle N+1 drives imem_we=1, imem_addr=pointer, imem_wdata=encoding (registered, 1-cycle latency). Pointer and word_count increment with the write.
  - Illegal accept: no write; err_illegal <= 1; pointer and word_count unchanged; in_last still honoured.
- LOAD -> DONE on an accepted beat with in_last=1, or on an accepted legal beat with pointer == MAX_ADDR. The pointer never wraps; that write still completes at N+1. in_ready = 0 from cycle N+1.
- DONE: in_ready = 0; holds word_count and err_illegal until next start.
- imem_we is a single-cycle strobe per word; back-to-back accepts give back-to-back writes.
- Encoding (opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6] = 0, funct[5:0]):
  - R-type, opcode 000000, funct: ADD 100000, SUB 100010, SLT 101010, MUL 011100.
  - I-type, rs / rt / imm[15:0]: ADDI 001000, LW 100011, SW 101011, BEQ 000100.
  - J: opcode 000010, target[25:0].
  - Fields not used by an op are forced to 0 regardless of inputs.
- Reset mid-LOAD: any pending write is squashed (imem_we = 0 in the cycle after rst) and the FSM returns to IDLE.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J).
  - funct constants (FN_ADD, FN_SUB, FN_SLT, FN_MUL).
  - op_sel enumeration.
  - The control decoder uses the same constants.
- Sub-module mips_instr_pack: purely combinational field packer plus legal flag. The top holds the FSM, pointer, counter and output register.

Test Plan:
- start base=0x10; ADD rs=1 rt=2 rd=3, in_last=1 -> next cycle imem_we=1, addr=0x10, wdata=0x00221820; done=1, word_count=1.
- Stream LW rt=8 rs=29 imm=0x0004, BEQ rs=1 rt=2 imm=0xFFFF, J target=0x10 back-to-back -> writes 0x8FA80004, 0x1022FFFF, 0x08000010 at consecutive addresses on consecutive cycles.
- ADDI rt=1 rs=0 imm=5 with rd=31 driven -> 0x20010005 (rd ignored); MUL rs=2 rt=3 rd=4 -> 0x0043201C.
- op_sel=12 mid-stream -> no write, err_illegal=1, next legal word lands at the un-advanced address.
- base=0xFE, three legal words, no in_last -> writes at 0xFE and 0xFF, then DONE; third word never accepted (in_ready=0), word_count=2.
- rst asserted the cycle after an accept -> imem_we=0, state IDLE, all outputs 0; a new start works normally.
